// File: rtl/avalon_onchip_ram_dp.sv
// Dual-slave Avalon-MM on-chip RAM on one true-dual-port array with byte enables.
// After reset a sequencer can zero-fill every word before either slave is served.
// Ports:
//   clk, reset_n (async, active-low), clken (global enable, 0 freezes the block)
//   sN_address/chipselect/read/write/byteenable/writedata : slave N request (N = 1, 2)
//   sN_readdata/readdatavalid : read response, READ_LATENCY enabled cycles after acceptance
//   sN_waitrequest : combinational, 1 = request not accepted this cycle
//   init_done : registered, 1 once the clear sequence has finished
module avalon_onchip_ram_dp #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           DEPTH          = 50000,
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter int unsigned           READ_LATENCY   = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter string                 INIT_FILE      = "onchip_ram_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    init_done
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
  localparam bit LAT2 = (READ_LATENCY == 2);

  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_e;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  // Power-up image is applied by the synthesis flow only; no logic depends on it.
  if (INIT_FILE == "") begin : g_no_init_file
  end

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    init_done_q, init_done_d;
  logic                    clear_we_c;
  logic                    base_wait_c;
  logic                    collide_c;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Per-slave views, index 0 = s1, index 1 = s2.
  logic [1:0]                 cs, rd, wr;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][NB-1:0]         be;
  logic [1:0][DATA_WIDTH-1:0] wdata;
  logic [1:0][IDX_W-1:0]      idx;
  logic [1:0]                 wait_c, in_range, wr_acc, rd_acc;
  logic [1:0][DATA_WIDTH-1:0] rword, wword;
  logic [IDX_W-1:0]           clr_idx;

  logic [1:0]                 v1_q, v1_d, v2_q, v2_d, vout;
  logic [1:0][DATA_WIDTH-1:0] d1_q, d1_d, d2_q, d2_d, dout;

  assign cs    = {s2_chipselect, s1_chipselect};
  assign rd    = {s2_read, s1_read};
  assign wr    = {s2_write, s1_write};
  assign addr  = {s2_address, s1_address};
  assign be    = {s2_byteenable, s1_byteenable};
  assign wdata = {s2_writedata, s1_writedata};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST_STATE;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state: clear walks one word per enabled cycle, then hands over to RUN.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (clken) begin
      case (state_q)
        S_CLEAR: begin
          if (clr_addr_q == LAST_A) state_d = S_RUN;
          else clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        end
        S_RUN: state_d = S_RUN;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    clear_we_c  = 1'b0;
    base_wait_c = 1'b1;
    case (state_q)
      S_CLEAR: clear_we_c  = clken & reset_n;
      S_RUN:   base_wait_c = ~clken;
    endcase
    if (!reset_n) base_wait_c = 1'b1;
    init_done_d = (state_d == S_RUN);
  end

  // Same-address double write: s1 wins, s2 is stalled one cycle so its data lands last.
  assign collide_c = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
  assign wait_c    = {base_wait_c | collide_c, base_wait_c};
  assign clr_idx   = IDX_W'(clr_addr_q);

  // Acceptance, range check, read-before-write data and byte-merged write word.
  always_comb begin
    idx      = '0;
    in_range = '0;
    wr_acc   = '0;
    rd_acc   = '0;
    rword    = '0;
    wword    = '0;
    for (int s = 0; s < 2; s++) begin
      idx[s]      = IDX_W'(addr[s]);
      in_range[s] = ({1'b0, addr[s]} < DEPTH_A);
      wr_acc[s]   = cs[s] & wr[s] & ~wait_c[s];
      // A simultaneous read is dropped in favour of the write.
      rd_acc[s]   = cs[s] & rd[s] & ~wr[s] & ~wait_c[s];
      rword[s]    = in_range[s] ? mem[idx[s]] : '0;
      for (int b = 0; b < NB; b++) begin
        wword[s][b*8 +: 8] = be[s][b] ? wdata[s][b*8 +: 8] : rword[s][b*8 +: 8];
      end
    end
  end

  // RAM array; clear and slave writes never coexist since slaves stall during CLEAR.
  always_ff @(posedge clk) begin
    if (clear_we_c) mem[clr_idx] <= CLEAR_VALUE;
    if (wr_acc[0] && in_range[0]) mem[idx[0]] <= wword[0];
    if (wr_acc[1] && in_range[1]) mem[idx[1]] <= wword[1];
  end

  // Read pipeline: advances only on enabled cycles; data regs load only with a valid.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    d1_d = d1_q;
    d2_d = d2_q;
    if (clken) begin
      v1_d = rd_acc;
      v2_d = v1_q;
      for (int s = 0; s < 2; s++) begin
        if (rd_acc[s]) d1_d[s] = rword[s];
        if (v1_q[s])   d2_d[s] = d1_q[s];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= '0;
      v2_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  assign vout = LAT2 ? v2_q : v1_q;
  assign dout = LAT2 ? d2_q : d1_q;

  // A pending valid is hidden while frozen and shows once clken returns.
  assign s1_readdatavalid = vout[0] & clken;
  assign s2_readdatavalid = vout[1] & clken;
  assign s1_readdata      = dout[0];
  assign s2_readdata      = dout[1];
  assign s1_waitrequest   = wait_c[0];
  assign s2_waitrequest   = wait_c[1];
  assign init_done        = init_done_q;

endmodule

// File: tb/tb_avalon_onchip_ram_dp.sv
module tb_avalon_onchip_ram_dp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 1;

  logic          clk, reset_n, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata;
  logic [DW-1:0] s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid;
  logic          s1_waitrequest, s2_waitrequest;
  logic          init_done;

  int total = 0;
  int bad   = 0;

  avalon_onchip_ram_dp #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(LAT),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h0), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .s2_waitrequest(s2_waitrequest),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic c, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    if (p == 1) begin
      s1_chipselect = c; s1_read = r; s1_write = w;
      s1_address = a; s1_writedata = d; s1_byteenable = b;
    end else begin
      s2_chipselect = c; s2_read = r; s2_write = w;
      s2_address = a; s2_writedata = d; s2_byteenable = b;
    end
  endtask

  task automatic idle(input int p);
    drive(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  function automatic logic wreq(input int p);
    return (p == 1) ? s1_waitrequest : s2_waitrequest;
  endfunction

  function automatic logic rvalid(input int p);
    return (p == 1) ? s1_readdatavalid : s2_readdatavalid;
  endfunction

  function automatic logic [31:0] rdata(input int p);
    return (p == 1) ? s1_readdata : s2_readdata;
  endfunction

  // Called #1 after a posedge with the request driven; returns #1 after the accepting edge.
  task automatic wait_accept(input int p);
    int n;
    n = 0;
    @(negedge clk);
    while (wreq(p) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (wreq(p)) check("accept_timeout", 32'(wreq(p)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic get_resp(input int p, output logic [31:0] d, output int lat);
    d   = 32'hxxxxxxxx;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rvalid(p)) begin
        d   = rdata(p);
        lat = k;
        break;
      end
    end
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    @(posedge clk);
    #1;
    drive(p, 1'b1, 1'b0, 1'b1, a, d, b);
    wait_accept(p);
    idle(p);
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, output logic [31:0] d, output int lat);
    @(posedge clk);
    #1;
    drive(p, 1'b1, 1'b1, 1'b0, a, '0, '0);
    wait_accept(p);
    idle(p);
    get_resp(p, d, lat);
  endtask

  // Called #1 after reset release; counts stalled cycles until the clear finishes.
  task automatic wait_init(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!s1_waitrequest) break;
      n++;
    end
  endtask

  logic [31:0] d;
  int          n, lat, cnt;
  int          pc [8];
  logic [31:0] pd [8];
  int          np;

  initial begin
    reset_n = 1'b0;
    clken   = 1'b1;
    idle(1);
    idle(2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s1_readdata", s1_readdata, 32'h0);
    check("rst_s1_valid", 32'(s1_readdatavalid), 32'd0);
    check("rst_s1_wait", 32'(s1_waitrequest), 32'd1);
    check("rst_s2_wait", 32'(s2_waitrequest), 32'd1);
    check("rst_init_done", 32'(init_done), 32'd0);

    // 1: clear sequence then all words zero
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_init(n);
    check("clear_stall_cycles", 32'(n), 32'(DEPTH));
    check("init_done_set", 32'(init_done), 32'd1);
    check("s2_wait_run", 32'(s2_waitrequest), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd(1, AW'(i), d, lat);
      check("clear_word", d, 32'h0);
    end
    check("clear_read_lat", 32'(lat), 32'(LAT));

    // 2: partial byte-enable write
    wr(1, AW'(3), 32'hAABBCCDD, 4'b0101);
    rd(1, AW'(3), d, lat);
    check("be_merge", d, 32'h00BB00DD);
    check("be_read_lat", 32'(lat), 32'(LAT));

    // 3: same-address write collision
    @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b0, 1'b1, AW'(5), 32'h11111111, 4'hF);
    drive(2, 1'b1, 1'b0, 1'b1, AW'(5), 32'h22222222, 4'hF);
    @(negedge clk);
    check("coll_s1_wait", 32'(s1_waitrequest), 32'd0);
    check("coll_s2_wait", 32'(s2_waitrequest), 32'd1);
    @(posedge clk);
    #1 idle(1);
    @(negedge clk);
    check("coll_s2_retry_wait", 32'(s2_waitrequest), 32'd0);
    @(posedge clk);
    #1 idle(2);
    rd(1, AW'(5), d, lat);
    check("coll_final_s1", d, 32'h22222222);
    rd(2, AW'(5), d, lat);
    check("coll_final_s2", d, 32'h22222222);

    // 4: s1 write vs s2 read at the same address -> old data first
    @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b0, 1'b1, AW'(7), 32'h00000005, 4'hF);
    drive(2, 1'b1, 1'b1, 1'b0, AW'(7), '0, '0);
    @(negedge clk);
    check("rbw_s1_wait", 32'(s1_waitrequest), 32'd0);
    check("rbw_s2_wait", 32'(s2_waitrequest), 32'd0);
    @(posedge clk);
    #1;
    idle(1);
    idle(2);
    get_resp(2, d, lat);
    check("rbw_old_data", d, 32'h0);
    check("rbw_lat", 32'(lat), 32'(LAT));
    rd(2, AW'(7), d, lat);
    check("rbw_new_data", d, 32'h5);

    // 5: burst of three reads with a two-cycle clken freeze
    for (int i = 0; i < 3; i++) wr(2, AW'(i), 32'hA0 + 32'(i), 4'hF);
    np = 0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      case (c)
        0:       begin clken = 1'b1; drive(1, 1'b1, 1'b1, 1'b0, AW'(0), '0, '0); end
        1, 2:    begin clken = 1'b0; drive(1, 1'b1, 1'b1, 1'b0, AW'(1), '0, '0); end
        3:       begin clken = 1'b1; drive(1, 1'b1, 1'b1, 1'b0, AW'(1), '0, '0); end
        4:       drive(1, 1'b1, 1'b1, 1'b0, AW'(2), '0, '0);
        default: idle(1);
      endcase
      @(negedge clk);
      if (c == 1) check("freeze_wait", 32'(s1_waitrequest), 32'd1);
      if (s1_readdatavalid && np < 8) begin
        pc[np] = c;
        pd[np] = s1_readdata;
        np++;
      end
      @(posedge clk);
      #1;
    end
    check("burst_pulses", 32'(np), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("burst_cycle", 32'(pc[i]), 32'(LAT + 2 + i));
      check("burst_data", pd[i], 32'hA0 + 32'(i));
    end

    // read and write together on one slave: write only, no response
    @(posedge clk);
    #1 drive(1, 1'b1, 1'b1, 1'b1, AW'(9), 32'h99, 4'hF);
    @(negedge clk);
    check("rw_wait", 32'(s1_waitrequest), 32'd0);
    @(posedge clk);
    #1 idle(1);
    cnt = 0;
    for (int k = 0; k < int'(LAT) + 3; k++) begin
      @(negedge clk);
      if (s1_readdatavalid) cnt++;
    end
    check("rw_no_valid", 32'(cnt), 32'd0);
    rd(1, AW'(9), d, lat);
    check("rw_write_done", d, 32'h99);

    // out-of-range: write ignored (no alias onto word 0), read returns zero
    wr(1, AW'(DEPTH), 32'hDEADBEEF, 4'hF);
    rd(1, AW'(0), d, lat);
    check("oor_no_alias", d, 32'hA0);
    rd(1, AW'(DEPTH), d, lat);
    check("oor_read_zero", d, 32'h0);
    check("oor_read_lat", 32'(lat), 32'(LAT));

    // 6: fill, reset mid-clear at clr_addr 8, clear restarts from 0
    for (int i = 0; i < int'(DEPTH); i++) wr(2, AW'(i), 32'h1000 + 32'(i), 4'hF);
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("midclr_rst_init_done", 32'(init_done), 32'd0);
    check("midclr_rst_wait", 32'(s2_waitrequest), 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_init(n);
    check("restart_stall_cycles", 32'(n), 32'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd((i % 2) + 1, AW'(i), d, lat);
      check("restart_word", d, 32'h0);
    end
    rd(1, AW'(DEPTH), d, lat);
    check("restart_oor_zero", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
